// File: rtl/regfile_wb_stage.sv
// Writeback staging FIFO in front of the integer register file.
// It drains up to NR_WB_PORTS entries per cycle and forwards the youngest buffered data to operand reads.
module regfile_wb_stage #(
    parameter int DATA_WIDTH    = 64,
    parameter int NR_WB_PORTS   = 2,
    parameter int DEPTH         = 4,
    parameter int NR_READ_PORTS = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  wb_valid_i,
    output logic                                  wb_ready_o,
    input  logic [4:0]                            wb_addr_i,
    input  logic [DATA_WIDTH-1:0]                 wb_data_i,
    input  logic                                  rf_stall_i,
    output logic [NR_WB_PORTS*5-1:0]              rf_waddr_o,
    output logic [NR_WB_PORTS*DATA_WIDTH-1:0]     rf_wdata_o,
    output logic [NR_WB_PORTS-1:0]                rf_we_o,
    input  logic [NR_READ_PORTS*5-1:0]            raddr_i,
    output logic [NR_READ_PORTS-1:0]              fwd_hit_o,
    output logic [NR_READ_PORTS*DATA_WIDTH-1:0]   fwd_data_o,
    output logic [$clog2(DEPTH+1)-1:0]            count_o,
    output logic                                  empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [4:0]            addr_q [DEPTH];
    logic [4:0]            addr_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    int unsigned           cnt;
    int unsigned           n_drain;
    logic                  push;
    logic [PTR_W-1:0]      drn_idx;
    logic [PTR_W-1:0]      fwd_idx;

    // Offsets never exceed 2*DEPTH-1, so a single conditional subtract wraps them.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int unsigned k);
        int unsigned s;
        s = 32'(p) + k;
        if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    assign cnt        = 32'(count_q);
    assign wb_ready_o = (count_q < CNT_W'(DEPTH)) | ~rf_stall_i;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);

    // Writes to x0 complete the handshake but never occupy a slot.
    assign push = wb_valid_i & wb_ready_o & (wb_addr_i != 5'd0);

    always_comb begin
        n_drain    = 0;
        drn_idx    = '0;
        rf_we_o    = '0;
        rf_waddr_o = '0;
        rf_wdata_o = '0;
        if (!rf_stall_i) n_drain = (cnt < 32'(NR_WB_PORTS)) ? cnt : 32'(NR_WB_PORTS);
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (32'(k) < n_drain) begin
                drn_idx                                = ptr_add(rd_ptr_q, 32'(k));
                rf_we_o[k]                             = 1'b1;
                rf_waddr_o[k*5 +: 5]                   = addr_q[drn_idx];
                rf_wdata_o[k*DATA_WIDTH +: DATA_WIDTH] = data_q[drn_idx];
            end
        end
    end

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit_o  = '0;
        fwd_data_o = '0;
        fwd_idx    = '0;
        for (int r = 0; r < NR_READ_PORTS; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (32'(k) < cnt) begin
                    fwd_idx = ptr_add(rd_ptr_q, 32'(k));
                    if ((raddr_i[r*5 +: 5] != 5'd0) && (addr_q[fwd_idx] == raddr_i[r*5 +: 5])) begin
                        fwd_hit_o[r]                           = 1'b1;
                        fwd_data_o[r*DATA_WIDTH +: DATA_WIDTH] = data_q[fwd_idx];
                    end
                end
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (push) begin
            addr_d[wr_ptr_q] = wb_addr_i;
            data_d[wr_ptr_q] = wb_data_i;
        end
        wr_ptr_d = push ? ptr_add(wr_ptr_q, 32'd1) : wr_ptr_q;
        rd_ptr_d = ptr_add(rd_ptr_q, n_drain);
        count_d  = CNT_W'(cnt + 32'(push) - n_drain);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: validity comes from count_q alone.
    always_ff @(posedge clk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

`ifndef SYNTHESIS
    a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= CNT_W'(DEPTH));
    a_we_thermo   : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     (rf_we_o & (rf_we_o + NR_WB_PORTS'(1))) == '0);
`endif

endmodule

// File: tb/tb_regfile_wb_stage.sv
// Directed bench for regfile_wb_stage with a queue-based reference model checked every cycle.
module tb_regfile_wb_stage;

    localparam int DW  = 64;
    localparam int NWB = 2;
    localparam int DEP = 4;
    localparam int NRP = 2;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic              wb_valid_i;
    logic              wb_ready_o;
    logic [4:0]        wb_addr_i;
    logic [DW-1:0]     wb_data_i;
    logic              rf_stall_i;
    logic [NWB*5-1:0]  rf_waddr_o;
    logic [NWB*DW-1:0] rf_wdata_o;
    logic [NWB-1:0]    rf_we_o;
    logic [NRP*5-1:0]  raddr_i;
    logic [NRP-1:0]    fwd_hit_o;
    logic [NRP*DW-1:0] fwd_data_o;
    logic [2:0]        count_o;
    logic              empty_o;

    regfile_wb_stage #(.DATA_WIDTH(DW), .NR_WB_PORTS(NWB), .DEPTH(DEP), .NR_READ_PORTS(NRP)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
        .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .rf_stall_i(rf_stall_i),
        .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .rf_we_o(rf_we_o),
        .raddr_i(raddr_i), .fwd_hit_o(fwd_hit_o), .fwd_data_o(fwd_data_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } ent_t;
    ent_t q[$];

    int                m_cnt, m_n;
    logic              m_ready;
    logic [NWB-1:0]    m_we;
    logic [NWB*5-1:0]  m_waddr;
    logic [NWB*DW-1:0] m_wdata;
    logic [NRP-1:0]    m_hit;
    logic [NRP*DW-1:0] m_fdata;
    logic [4:0]        m_ra;
    ent_t              m_e;

    // Expected outputs follow from the queue contents and the current inputs; the queue then advances.
    always @(negedge clk) begin
        if (!rst_ni) q.delete();
        m_cnt   = q.size();
        m_n     = rf_stall_i ? 0 : ((m_cnt < NWB) ? m_cnt : NWB);
        m_ready = (m_cnt < DEP) || !rf_stall_i;
        m_we    = '0;
        m_waddr = '0;
        m_wdata = '0;
        for (int k = 0; k < m_n; k++) begin
            m_we[k]               = 1'b1;
            m_waddr[k*5 +: 5]     = q[k].a;
            m_wdata[k*DW +: DW]   = q[k].d;
        end
        m_hit   = '0;
        m_fdata = '0;
        for (int r = 0; r < NRP; r++) begin
            m_ra = raddr_i[r*5 +: 5];
            for (int i = 0; i < m_cnt; i++) begin
                if (m_ra != 5'd0 && q[i].a == m_ra) begin
                    m_hit[r]           = 1'b1;
                    m_fdata[r*DW +: DW] = q[i].d;
                end
            end
        end
        chk("m_ready", 256'(wb_ready_o), 256'(m_ready));
        chk("m_we",    256'(rf_we_o),    256'(m_we));
        chk("m_waddr", 256'(rf_waddr_o), 256'(m_waddr));
        chk("m_wdata", 256'(rf_wdata_o), 256'(m_wdata));
        chk("m_count", 256'(count_o),    256'(m_cnt));
        chk("m_empty", 256'(empty_o),    256'(m_cnt == 0));
        chk("m_hit",   256'(fwd_hit_o),  256'(m_hit));
        chk("m_fdata", 256'(fwd_data_o), 256'(m_fdata));
        if (rst_ni) begin
            for (int k = 0; k < m_n; k++) void'(q.pop_front());
            if (wb_valid_i && m_ready && wb_addr_i != 5'd0) begin
                m_e.a = wb_addr_i;
                m_e.d = wb_data_i;
                q.push_back(m_e);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [DW-1:0] d);
        wb_valid_i = 1'b1;
        wb_addr_i  = a;
        wb_data_i  = d;
        cyc();
        wb_valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
        rf_stall_i = 1'b0; raddr_i = '0;
        cyc(); cyc();
        #1;
        chk("rst_count", 256'(count_o), 256'(0));
        chk("rst_empty", 256'(empty_o), 256'(1));
        chk("rst_we",    256'(rf_we_o), 256'(0));
        rst_ni = 1'b1;
        cyc();
        chk("rel_ready", 256'(wb_ready_o), 256'(1));

        // single write
        wb_valid_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 64'hDEAD_BEEF_0000_0001;
        #1 chk("t1_we_before", 256'(rf_we_o), 256'(0));
        cyc(); wb_valid_i = 1'b0;
        #1;
        chk("t1_we",    256'(rf_we_o), 256'(2'b01));
        chk("t1_addr",  256'(rf_waddr_o[4:0]), 256'(5));
        chk("t1_data",  256'(rf_wdata_o[63:0]), 256'(64'hDEAD_BEEF_0000_0001));
        chk("t1_cnt1",  256'(count_o), 256'(1));
        cyc(); #1;
        chk("t1_cnt0",  256'(count_o), 256'(0));
        chk("t1_empty", 256'(empty_o), 256'(1));

        // stall then burst
        rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 64'(i * 'h11));
        #1;
        chk("t2_cnt4",  256'(count_o), 256'(4));
        chk("t2_ready", 256'(wb_ready_o), 256'(0));
        rf_stall_i = 1'b0;
        #1;
        chk("t2_we_a",   256'(rf_we_o), 256'(2'b11));
        chk("t2_addr_a", 256'(rf_waddr_o), 256'({5'd2, 5'd1}));
        chk("t2_data_a", 256'(rf_wdata_o), 256'({64'h22, 64'h11}));
        cyc(); #1;
        chk("t2_we_b",   256'(rf_we_o), 256'(2'b11));
        chk("t2_addr_b", 256'(rf_waddr_o), 256'({5'd4, 5'd3}));
        chk("t2_data_b", 256'(rf_wdata_o), 256'({64'h44, 64'h33}));
        cyc(); #1;
        chk("t2_empty",  256'(empty_o), 256'(1));
        chk("t2_we_off", 256'(rf_we_o), 256'(0));

        // full with concurrent push
        rf_stall_i = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 64'(i * 'h11));
        rf_stall_i = 1'b0;
        wb_valid_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 64'h77;
        #1 chk("t3_ready", 256'(wb_ready_o), 256'(1));
        cyc(); wb_valid_i = 1'b0;
        #1;
        chk("t3_cnt3", 256'(count_o), 256'(3));
        chk("t3_addr", 256'(rf_waddr_o), 256'({5'd4, 5'd3}));
        cyc(); #1;
        chk("t3_cnt1",  256'(count_o), 256'(1));
        chk("t3_we",    256'(rf_we_o), 256'(2'b01));
        chk("t3_addr7", 256'(rf_waddr_o[4:0]), 256'(7));
        chk("t3_data7", 256'(rf_wdata_o[63:0]), 256'(64'h77));
        cyc(); #1;
        chk("t3_empty", 256'(empty_o), 256'(1));

        // forwarding of the youngest match
        rf_stall_i = 1'b1;
        raddr_i = {5'd9, 5'd0};
        wb_valid_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 64'hA;
        #1 chk("t4_no_incoming_fwd", 256'(fwd_hit_o), 256'(0));
        cyc(); wb_data_i = 64'hB;
        #1;
        chk("t4_hit_a",  256'(fwd_hit_o), 256'(2'b10));
        chk("t4_data_a", 256'(fwd_data_o[127:64]), 256'(64'hA));
        cyc(); wb_valid_i = 1'b0;
        #1;
        chk("t4_hit_b",  256'(fwd_hit_o), 256'(2'b10));
        chk("t4_data_b", 256'(fwd_data_o[127:64]), 256'(64'hB));
        chk("t4_data_0", 256'(fwd_data_o[63:0]), 256'(0));
        rf_stall_i = 1'b0;
        #1 chk("t4_drain_same", 256'(rf_waddr_o), 256'({5'd9, 5'd9}));
        cyc(); raddr_i = '0;
        #1 chk("t4_empty", 256'(empty_o), 256'(1));

        // x0 write is dropped
        wb_valid_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 64'hFF;
        #1 chk("t5_ready", 256'(wb_ready_o), 256'(1));
        cyc(); wb_valid_i = 1'b0;
        #1;
        chk("t5_cnt", 256'(count_o), 256'(0));
        chk("t5_we",  256'(rf_we_o), 256'(0));

        // reset mid-burst
        rf_stall_i = 1'b1;
        push(5'd10, 64'h100); push(5'd11, 64'h101); push(5'd12, 64'h102);
        raddr_i = {5'd11, 5'd10};
        rf_stall_i = 1'b0;
        #1;
        chk("t6_we_pre",  256'(rf_we_o), 256'(2'b11));
        chk("t6_hit_pre", 256'(fwd_hit_o), 256'(2'b11));
        #1 rst_ni = 1'b0;
        #1;
        chk("t6_we_rst",  256'(rf_we_o), 256'(0));
        chk("t6_cnt_rst", 256'(count_o), 256'(0));
        chk("t6_hit_rst", 256'(fwd_hit_o), 256'(0));
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc(); #1;
        chk("t6_we_post",    256'(rf_we_o), 256'(0));
        chk("t6_empty_post", 256'(empty_o), 256'(1));
        cyc(); cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
